// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared widths and state type for the JAM cost host
package jam_pkg;
   localparam int N    = 8;
   localparam int CW   = 7;
   localparam int MINW = 10;
   localparam int CNTW = 4;
   localparam int IDXW = 6;
   localparam int CYCW = 17;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      HOLD  = 2'd1,
      SERVE = 2'd2,
      DONE  = 2'd3
   } host_state_t;
endpackage

// File: rtl/jam_cost_mem.sv
// rtl/jam_cost_mem.sv - 64-entry cost register file, one write port, one registered read port
module jam_cost_mem #(
   parameter int CW = 7
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          we,
   input  logic [5:0]    waddr,
   input  logic [CW-1:0] wdata,
   input  logic          re,
   input  logic [5:0]    raddr,
   output logic [CW-1:0] rdata
);
   logic [CW-1:0] r_mem [64];
   logic [CW-1:0] r_rdata;

   // Storage is deliberately left unreset; a full reload always follows reset.
   always_ff @(posedge CLK) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= re ? r_mem[raddr] : '0;
      end
   end

   assign rdata = r_rdata;
endmodule

// File: rtl/jam_cost_host.sv
// rtl/jam_cost_host.sv - cost table host: loads the table, holds JAM in reset, serves reads, checks results
module jam_cost_host
   import jam_pkg::*;
#(
   parameter int CW       = 7,
   parameter int HOLD_CYC = 2,
   parameter int TIMEOUT  = 65535
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [CW-1:0]   ld_data,
   input  logic [MINW-1:0] exp_min,
   input  logic [CNTW-1:0] exp_cnt,
   output logic            jam_rst,
   input  logic [2:0]      W,
   input  logic [2:0]      J,
   output logic [CW-1:0]   Cost,
   input  logic [MINW-1:0] MinCost,
   input  logic [CNTW-1:0] MatchCount,
   input  logic            Valid,
   output logic            done,
   output logic            pass,
   output logic            timeout
);
   host_state_t     r_state;
   logic [IDXW-1:0] r_idx;
   logic [7:0]      r_hold;
   logic [CYCW-1:0] r_cyc;
   logic [MINW-1:0] r_exp_min;
   logic [CNTW-1:0] r_exp_cnt;
   logic            r_jam_rst;
   logic            r_done;
   logic            r_pass;
   logic            r_timeout;

   logic            w_ld_hs;
   logic            w_serve;
   logic [CW-1:0]   w_rdata;

   assign ld_ready = (r_state == LOAD);
   assign w_ld_hs  = ld_valid && ld_ready;
   assign w_serve  = (r_state == SERVE);

   jam_cost_mem #(.CW(CW)) u_mem (
      .CLK   (CLK),
      .RST   (RST),
      .we    (w_ld_hs),
      .waddr (r_idx),
      .wdata (ld_data),
      .re    (w_serve),
      .raddr ({W, J}),
      .rdata (w_rdata)
   );

   // Read data is zero on the first SERVE cycle because the read port is disabled in HOLD.
   assign Cost    = w_serve ? w_rdata : '0;
   assign jam_rst = r_jam_rst;
   assign done    = r_done;
   assign pass    = r_pass;
   assign timeout = r_timeout;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= LOAD;
         r_idx     <= '0;
         r_hold    <= '0;
         r_cyc     <= '0;
         r_exp_min <= '0;
         r_exp_cnt <= '0;
         r_jam_rst <= 1'b1;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_ld_hs) begin
                  r_idx <= r_idx + 6'd1;
                  if (r_idx == 6'd63) begin
                     r_exp_min <= exp_min;
                     r_exp_cnt <= exp_cnt;
                     r_hold    <= '0;
                     r_state   <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (r_hold == 8'(HOLD_CYC - 1)) begin
                  r_state   <= SERVE;
                  r_jam_rst <= 1'b0;
                  r_cyc     <= '0;
               end else begin
                  r_hold <= r_hold + 8'd1;
               end
            end
            SERVE: begin
               // A result arriving on the last allowed cycle still counts.
               if (Valid) begin
                  r_pass  <= (MinCost == r_exp_min) && (MatchCount == r_exp_cnt);
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (r_cyc >= CYCW'(TIMEOUT - 1)) begin
                  r_timeout <= 1'b1;
                  r_pass    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end else if (r_cyc != {CYCW{1'b1}}) begin
                  r_cyc <= r_cyc + 17'd1;
               end
            end
            DONE: begin
               r_state <= DONE;
            end
            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_jam_cost_host.sv
// tb/tb_jam_cost_host.sv - randomized scoreboard bench for jam_cost_host with a behavioural JAM model
module tb_jam_cost_host;
   localparam int CW       = 7;
   localparam int HOLD_CYC = 2;
   localparam int TIMEOUT  = 100;

   logic          CLK = 1'b0;
   logic          RST;
   logic          ld_valid;
   logic          ld_ready;
   logic [CW-1:0] ld_data;
   logic [9:0]    exp_min;
   logic [3:0]    exp_cnt;
   logic          jam_rst;
   logic [2:0]    W;
   logic [2:0]    J;
   logic [CW-1:0] Cost;
   logic [9:0]    MinCost;
   logic [3:0]    MatchCount;
   logic          Valid;
   logic          done;
   logic          pass;
   logic          timeout;

   jam_cost_host #(.CW(CW), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .exp_min    (exp_min),
      .exp_cnt    (exp_cnt),
      .jam_rst    (jam_rst),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .MinCost    (MinCost),
      .MatchCount (MatchCount),
      .Valid      (Valid),
      .done       (done),
      .pass       (pass),
      .timeout    (timeout)
   );

   always #5 CLK = ~CLK;

   typedef struct {int due; int addr; int exp;} rd_t;
   typedef struct {int epass; int etmo;} res_t;

   rd_t  cost_q[$];
   res_t res_q[$];
   int   ref_tab[64];
   int   got_tab[64];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   sc       = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Brute-force assignment problem over all 8! permutations.
   function automatic void best(input int tab[64], output int mn, output int cnt);
      int p[8];
      int s, i, j, t, a, b;
      for (int k = 0; k < 8; k++) p[k] = k;
      mn  = 1 << 30;
      cnt = 0;
      while (1) begin
         s = 0;
         for (int k = 0; k < 8; k++) s += tab[k*8 + p[k]];
         if (s < mn) begin
            mn = s; cnt = 1;
         end else if (s == mn) begin
            cnt++;
         end
         i = 6;
         while (i >= 0 && p[i] > p[i+1]) i--;
         if (i < 0) break;
         j = 7;
         while (p[j] < p[i]) j--;
         t = p[i]; p[i] = p[j]; p[j] = t;
         a = i + 1; b = 7;
         while (a < b) begin
            t = p[a]; p[a] = p[b]; p[b] = t;
            a++; b--;
         end
      end
      if (cnt > 15) cnt = 15;
   endfunction

   // Monitor: pops expected read data and results as the DUT produces them.
   initial begin
      rd_t  it;
      res_t r;
      logic prev_done = 1'b0;
      forever begin
         @(negedge CLK);
         while (cost_q.size() > 0 && cost_q[0].due <= cyc) begin
            it = cost_q.pop_front();
            chk("cost_latency", cyc, it.due);
            chk($sformatf("cost[%0d]", it.addr), int'(Cost), it.exp);
            got_tab[it.addr] = int'(Cost);
         end
         if (done && !prev_done) begin
            if (res_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               r = res_q.pop_front();
               chk("pass", int'(pass), r.epass);
               chk("timeout", int'(timeout), r.etmo);
            end
         end
         prev_done = done;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
      sc++;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      ld_valid = 1'b0; Valid = 1'b0; W = '0; J = '0;
      cost_q.delete();
      step();
      RST = 1'b0;
   endtask

   task automatic fill_diag();
      for (int k = 0; k < 64; k++) ref_tab[k] = ((k >> 3) == (k & 7)) ? 0 : 10;
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 64; k++) ref_tab[k] = int'($urandom_range(0, 127));
   endtask

   task automatic load_table(input bit gaps, input int emin, input int ecnt);
      for (int k = 0; k < 64; k++) begin
         if (gaps && (k % 2 == 1)) begin
            ld_valid = 1'b0;
            ld_data  = CW'($urandom);
            step();
         end
         ld_valid = 1'b1;
         ld_data  = CW'(ref_tab[k]);
         exp_min  = (k == 63) ? 10'(emin) : 10'($urandom);
         exp_cnt  = (k == 63) ? 4'(ecnt)  : 4'($urandom);
         step();
      end
      ld_valid = 1'b0;
      exp_min  = 10'($urandom);
      exp_cnt  = 4'($urandom);
      chk("hold1_jam_rst", int'(jam_rst), 1);
      chk("hold_ld_ready", int'(ld_ready), 0);
      chk("hold_cost", int'(Cost), 0);
      step();
      chk("hold2_jam_rst", int'(jam_rst), 1);
      step();
      chk("serve_jam_rst", int'(jam_rst), 0);
      chk("serve_first_cost", int'(Cost), 0);
      sc = 1;
   endtask

   task automatic issue_read(input int k);
      rd_t it;
      W = 3'(k >> 3);
      J = 3'(k & 7);
      it.due = cyc + 1; it.addr = k; it.exp = ref_tab[k];
      cost_q.push_back(it);
   endtask

   task automatic serve_reads(input int n, input bit junk_ld);
      for (int k = 0; k < n; k++) begin
         issue_read(k);
         if (junk_ld) begin
            ld_valid = 1'b1;
            ld_data  = CW'($urandom);
         end
         step();
      end
      ld_valid = 1'b0;
      step();
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 10) begin
         step();
         t++;
      end
      chk("done_seen", int'(done), 1);
      step();
   endtask

   task automatic give_valid(input int emin, input int ecnt);
      int rmn, rcnt, gmn, gcnt;
      res_t r;
      best(ref_tab, rmn, rcnt);
      best(got_tab, gmn, gcnt);
      r.epass = (rmn == emin && rcnt == ecnt) ? 1 : 0;
      r.etmo  = 0;
      res_q.push_back(r);
      MinCost    = 10'(gmn);
      MatchCount = 4'(gcnt);
      Valid      = 1'b1;
      step();
      Valid = 1'b0;
      wait_done();
   endtask

   task automatic full_run(input bit gaps, input int emin, input int ecnt);
      load_table(gaps, emin, ecnt);
      serve_reads(64, gaps);
      give_valid(emin, ecnt);
   endtask

   initial begin
      int rmn, rcnt;
      res_t r;
      RST = 1'b1; ld_valid = 1'b0; ld_data = '0; exp_min = '0; exp_cnt = '0;
      W = '0; J = '0; MinCost = '0; MatchCount = '0; Valid = 1'b0;
      #1;
      chk("rst_ld_ready", int'(ld_ready), 1);
      chk("rst_jam_rst", int'(jam_rst), 1);
      chk("rst_cost", int'(Cost), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_timeout", int'(timeout), 0);
      do_reset();

      // 1: diagonal table, matching expectations
      fill_diag();
      full_run(1'b0, 0, 1);
      chk("t1_done", int'(done), 1);
      MinCost = 10'd999; MatchCount = 4'd9; Valid = 1'b1;
      step();
      Valid = 1'b0;
      step();
      chk("t1_sticky_done", int'(done), 1);
      chk("t1_sticky_pass", int'(pass), 1);
      chk("t1_done_cost", int'(Cost), 0);

      // 2: gapped load of a random table, junk ld_valid during SERVE, explicit (3,5) read
      do_reset();
      fill_rand();
      best(ref_tab, rmn, rcnt);
      load_table(1'b1, rmn, rcnt);
      serve_reads(64, 1'b1);
      issue_read(29);
      step();
      issue_read(0);
      step();
      step();
      give_valid(rmn, rcnt);

      // 3: diagonal table with wrong expected minimum
      do_reset();
      fill_diag();
      full_run(1'b0, 1, 1);

      // 4: no result from JAM -> timeout on the 100th SERVE cycle
      do_reset();
      fill_rand();
      load_table(1'b0, 0, 0);
      serve_reads(64, 1'b0);
      while (sc < TIMEOUT) step();
      chk("t4_no_early_done", int'(done), 0);
      r.epass = 0; r.etmo = 1;
      res_q.push_back(r);
      step();
      chk("t4_done_at_limit", int'(done), 1);
      step();

      // 5: reset in the middle of SERVE, then a reload with a new table
      do_reset();
      fill_rand();
      load_table(1'b0, 0, 0);
      serve_reads(10, 1'b0);
      RST = 1'b1;
      cost_q.delete();
      #1;
      chk("t5_async_jam_rst", int'(jam_rst), 1);
      chk("t5_async_ld_ready", int'(ld_ready), 1);
      step();
      chk("t5_jam_rst", int'(jam_rst), 1);
      chk("t5_cost", int'(Cost), 0);
      chk("t5_ld_ready", int'(ld_ready), 1);
      chk("t5_done", int'(done), 0);
      RST = 1'b0;
      fill_rand();
      best(ref_tab, rmn, rcnt);
      full_run(1'b0, rmn, rcnt);

      // 6: Valid arrives on the same cycle the timeout condition fires
      do_reset();
      fill_diag();
      load_table(1'b0, 0, 1);
      serve_reads(64, 1'b0);
      while (sc < TIMEOUT) step();
      chk("t6_no_early_done", int'(done), 0);
      give_valid(0, 1);

      chk("res_q_drained", res_q.size(), 0);
      chk("cost_q_drained", cost_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
